// File: rtl/dram_reader_burst.sv
// AXI3 read master streaming a contiguous DRAM region to a valid/ready port.
// Optional feature macro: DRAM_READER_RLAST_CHECK_EN (check RLAST against issued ARLENs).
//
// state    | meaning
// A_IDLE   | no burst addresses left to issue
// A_ISSUE  | issuing bursts, throttled by the outstanding limit
// R_IDLE   | no read beats expected
// R_RUN    | forwarding read beats to dout
module dram_reader_burst #(
   parameter int DATA_W          = 64,
   parameter int BURST_LEN       = 16,
   parameter int MAX_OUTSTANDING = 4,
   parameter int ADDR_W          = 32
) (
   input  logic              ACLK,
   input  logic              ARESETN,
   output logic [ADDR_W-1:0] M_AXI_ARADDR,
   output logic              M_AXI_ARVALID,
   input  logic              M_AXI_ARREADY,
   output logic [3:0]        M_AXI_ARLEN,
   output logic [2:0]        M_AXI_ARSIZE,
   output logic [1:0]        M_AXI_ARBURST,
   input  logic [DATA_W-1:0] M_AXI_RDATA,
   input  logic [1:0]        M_AXI_RRESP,
   input  logic              M_AXI_RLAST,
   input  logic              M_AXI_RVALID,
   output logic              M_AXI_RREADY,
   input  logic              CONFIG_VALID,
   output logic              CONFIG_READY,
   input  logic [ADDR_W-1:0] CONFIG_START_ADDR,
   input  logic [ADDR_W-1:0] CONFIG_NBYTES,
   output logic [DATA_W-1:0] dout,
   output logic              dout_valid,
   input  logic              dout_ready,
   output logic              dout_last,
   output logic              ERROR
);
   localparam int BB    = DATA_W / 8;
   localparam int BB_LG = $clog2(BB);
   localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);
   localparam logic [ADDR_W-1:0] BURST_BYTES = ADDR_W'(BURST_LEN * BB);
   localparam logic [3:0]        FULL_LEN    = 4'(BURST_LEN - 1);

   typedef enum logic {A_IDLE, A_ISSUE} a_state_t;
   typedef enum logic {R_IDLE, R_RUN}   r_state_t;

   a_state_t          a_state, a_state_nxt;
   r_state_t          r_state, r_state_nxt;
   logic [ADDR_W-1:0] araddr_q;
   logic [ADDR_W-1:0] beats_left_a;
   logic [ADDR_W-1:0] beats_left_r;
   logic [ADDR_W-1:0] total_beats;
   logic [ADDR_W-1:0] burst_beats;
   logic [OUT_W-1:0]  outstanding;
   logic [3:0]        arlen;
   logic              accept;
   logic              start;
   logic              ar_hs;
   logic              r_beat;
   logic              burst_end;
   logic              last_err;
   logic              error_q;

   assign total_beats  = CONFIG_NBYTES >> BB_LG;
   assign CONFIG_READY = (a_state == A_IDLE) && (r_state == R_IDLE);
   assign accept       = CONFIG_VALID && CONFIG_READY;
   assign start        = accept && (total_beats != '0);

   // Final burst is shortened to the beats that remain.
   assign arlen       = (beats_left_a >= ADDR_W'(BURST_LEN)) ? FULL_LEN
                                                              : beats_left_a[3:0] - 4'd1;
   assign burst_beats = {{(ADDR_W-4){1'b0}}, arlen} + ADDR_W'(1);

   assign M_AXI_ARVALID = (a_state == A_ISSUE) && (outstanding < OUT_W'(MAX_OUTSTANDING));
   assign M_AXI_ARADDR  = araddr_q;
   assign M_AXI_ARLEN   = arlen;
   assign M_AXI_ARSIZE  = 3'(BB_LG);
   assign M_AXI_ARBURST = 2'b01;
   assign ar_hs         = M_AXI_ARVALID && M_AXI_ARREADY;

   assign M_AXI_RREADY = (r_state == R_RUN) && dout_ready;
   assign dout_valid   = (r_state == R_RUN) && M_AXI_RVALID;
   assign dout         = M_AXI_RDATA;
   assign dout_last    = dout_valid && (beats_left_r == ADDR_W'(1));
   assign r_beat       = (r_state == R_RUN) && M_AXI_RVALID && dout_ready;
   assign ERROR        = error_q;

`ifdef DRAM_READER_RLAST_CHECK_EN
   localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

   logic [3:0]       len_fifo [MAX_OUTSTANDING];
   logic [PTR_W-1:0] wr_ptr, rd_ptr;
   logic [3:0]       beat_in_burst;
   logic             exp_last;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
   endfunction

   assign exp_last  = (outstanding != '0) && (beat_in_burst == len_fifo[rd_ptr]);
   assign burst_end = r_beat && exp_last;
   assign last_err  = r_beat && (M_AXI_RLAST != exp_last);

   always_ff @(posedge ACLK) begin
      if (ar_hs) len_fifo[wr_ptr] <= arlen;
   end

   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         wr_ptr        <= '0;
         rd_ptr        <= '0;
         beat_in_burst <= '0;
      end else begin
         if (ar_hs) wr_ptr <= ptr_inc(wr_ptr);
         if (burst_end) begin
            rd_ptr        <= ptr_inc(rd_ptr);
            beat_in_burst <= '0;
         end else if (r_beat) begin
            beat_in_burst <= beat_in_burst + 4'd1;
         end
      end
   end
`else
   assign burst_end = r_beat && M_AXI_RLAST;
   assign last_err  = 1'b0;
`endif

   always_comb begin
      a_state_nxt = a_state;
      r_state_nxt = r_state;
      case (a_state)
         A_IDLE:  if (start) a_state_nxt = A_ISSUE;
         A_ISSUE: if (ar_hs && (beats_left_a == burst_beats)) a_state_nxt = A_IDLE;
         default: a_state_nxt = A_IDLE;
      endcase
      case (r_state)
         R_IDLE:  if (start) r_state_nxt = R_RUN;
         R_RUN:   if (r_beat && (beats_left_r == ADDR_W'(1))) r_state_nxt = R_IDLE;
         default: r_state_nxt = R_IDLE;
      endcase
   end

   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         a_state      <= A_IDLE;
         r_state      <= R_IDLE;
         araddr_q     <= '0;
         beats_left_a <= '0;
         beats_left_r <= '0;
         outstanding  <= '0;
         error_q      <= 1'b0;
      end else begin
         a_state <= a_state_nxt;
         r_state <= r_state_nxt;
         if (accept) begin
            araddr_q     <= CONFIG_START_ADDR;
            beats_left_a <= total_beats;
            beats_left_r <= total_beats;
         end else begin
            if (ar_hs) begin
               araddr_q     <= araddr_q + BURST_BYTES;
               beats_left_a <= beats_left_a - burst_beats;
            end
            if (r_beat) beats_left_r <= beats_left_r - ADDR_W'(1);
         end
         // A burst closing in the same cycle as a new issue leaves the count unchanged.
         if (ar_hs && !burst_end)
            outstanding <= outstanding + OUT_W'(1);
         else if (!ar_hs && burst_end && (outstanding != '0))
            outstanding <= outstanding - OUT_W'(1);
         if (accept)
            error_q <= 1'b0;
         else if ((r_beat && (M_AXI_RRESP != 2'b00)) || last_err)
            error_q <= 1'b1;
      end
   end
endmodule

// File: tb/tb_dram_reader_burst.sv
// Bench for dram_reader_burst: directed steps plus randomized transfers against a
// queue-based reference model and a simple AXI read slave.
module tb_dram_reader_burst;
   localparam int DATA_W = 64;
   localparam int BLEN   = 16;
   localparam int MAXO   = 2;
   localparam int ADDR_W = 32;

   logic              ACLK = 1'b0;
   logic              ARESETN = 1'b0;
   logic [31:0]       M_AXI_ARADDR;
   logic              M_AXI_ARVALID;
   logic              M_AXI_ARREADY;
   logic [3:0]        M_AXI_ARLEN;
   logic [2:0]        M_AXI_ARSIZE;
   logic [1:0]        M_AXI_ARBURST;
   logic [63:0]       M_AXI_RDATA;
   logic [1:0]        M_AXI_RRESP;
   logic              M_AXI_RLAST;
   logic              M_AXI_RVALID;
   logic              M_AXI_RREADY;
   logic              CONFIG_VALID;
   logic              CONFIG_READY;
   logic [31:0]       CONFIG_START_ADDR;
   logic [31:0]       CONFIG_NBYTES;
   logic [63:0]       dout;
   logic              dout_valid;
   logic              dout_ready;
   logic              dout_last;
   logic              ERROR;

   dram_reader_burst #(.DATA_W(DATA_W), .BURST_LEN(BLEN), .MAX_OUTSTANDING(MAXO),
                       .ADDR_W(ADDR_W)) dut (
      .ACLK(ACLK), .ARESETN(ARESETN),
      .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARVALID(M_AXI_ARVALID),
      .M_AXI_ARREADY(M_AXI_ARREADY), .M_AXI_ARLEN(M_AXI_ARLEN),
      .M_AXI_ARSIZE(M_AXI_ARSIZE), .M_AXI_ARBURST(M_AXI_ARBURST),
      .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP), .M_AXI_RLAST(M_AXI_RLAST),
      .M_AXI_RVALID(M_AXI_RVALID), .M_AXI_RREADY(M_AXI_RREADY),
      .CONFIG_VALID(CONFIG_VALID), .CONFIG_READY(CONFIG_READY),
      .CONFIG_START_ADDR(CONFIG_START_ADDR), .CONFIG_NBYTES(CONFIG_NBYTES),
      .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
      .dout_last(dout_last), .ERROR(ERROR));

   always #5 ACLK = ~ACLK;

   int vectors = 0;
   int miscompares = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // reference model: expected AR sequence and expected output beats
   logic [31:0] exp_ar_addr[$];
   logic [3:0]  exp_ar_len[$];
   logic [63:0] exp_data[$];
   int          outs, ar_count, beat_count, last_count, err_beat;
   bit          exp_err;
   // slave state
   logic [31:0] sl_addr[$];
   logic [3:0]  sl_len[$];
   int          sl_beat;
   bit          sl_taken;
   int          ar_mode, r_mode, d_mode;
   bit          d_tog;
   bit          prev_stall;
   logic [31:0] prev_araddr;
   logic [3:0]  prev_arlen;

   function automatic logic [63:0] mem_word(input logic [31:0] a);
      return {a ^ 32'h5A5A_C3C3, ~a + 32'd17};
   endfunction

   task automatic plan_transfer(input logic [31:0] start, input logic [31:0] nbytes);
      int beats, n;
      logic [31:0] a;
      beats = int'(nbytes / 8);
      a = start;
      for (int i = 0; i < beats; i++) exp_data.push_back(mem_word(start + 32'(8 * i)));
      while (beats > 0) begin
         n = (beats > BLEN) ? BLEN : beats;
         exp_ar_addr.push_back(a);
         exp_ar_len.push_back(4'(n - 1));
         a = a + 32'(BLEN * 8);
         beats -= n;
      end
   endtask

   always @(negedge ACLK) begin
      bit active, m_ready, ar_hs, r_hs;
      if (!ARESETN) begin
         exp_ar_addr.delete(); exp_ar_len.delete(); exp_data.delete();
         sl_addr.delete(); sl_len.delete();
         sl_beat = 0; sl_taken = 0; outs = 0; exp_err = 0; prev_stall = 0;
      end else begin
         active  = exp_data.size() > 0;
         m_ready = !active && exp_ar_addr.size() == 0;
         chk("config_ready", CONFIG_READY, m_ready);
         chk("arvalid", M_AXI_ARVALID, exp_ar_addr.size() > 0 && outs < MAXO);
         chk("rready", M_AXI_RREADY, active && dout_ready);
         chk("dout_valid", dout_valid, active && M_AXI_RVALID);
         chk("dout_last", dout_last, active && M_AXI_RVALID && exp_data.size() == 1);
         chk("error", ERROR, exp_err);
         if (active && M_AXI_RVALID) chk("dout", dout, exp_data[0]);
         if (prev_stall) begin
            chk("araddr_stable", M_AXI_ARADDR, prev_araddr);
            chk("arlen_stable", M_AXI_ARLEN, prev_arlen);
         end
         if (M_AXI_ARVALID && exp_ar_addr.size() > 0) begin
            chk("araddr", M_AXI_ARADDR, exp_ar_addr[0]);
            chk("arlen", M_AXI_ARLEN, exp_ar_len[0]);
         end
         ar_hs = M_AXI_ARVALID && M_AXI_ARREADY;
         r_hs  = active && M_AXI_RVALID && dout_ready;
         prev_stall  = M_AXI_ARVALID && !M_AXI_ARREADY;
         prev_araddr = M_AXI_ARADDR;
         prev_arlen  = M_AXI_ARLEN;
         if (ar_hs) begin
            ar_count++;
            outs++;
            sl_addr.push_back(M_AXI_ARADDR);
            sl_len.push_back(M_AXI_ARLEN);
            if (exp_ar_addr.size() > 0) begin
               void'(exp_ar_addr.pop_front());
               void'(exp_ar_len.pop_front());
            end
         end
         if (r_hs) begin
            beat_count++;
            if (dout_last) last_count++;
            if (M_AXI_RRESP != 2'b00) exp_err = 1;
            void'(exp_data.pop_front());
            if (M_AXI_RLAST) outs--;
            sl_taken = 1;
            if (sl_addr.size() > 0) begin
               if (sl_beat == int'(sl_len[0])) begin
                  void'(sl_addr.pop_front());
                  void'(sl_len.pop_front());
                  sl_beat = 0;
               end else begin
                  sl_beat++;
               end
            end
         end
         if (CONFIG_VALID && m_ready) begin
            exp_err = 0;
            ar_count = 0; beat_count = 0; last_count = 0;
            plan_transfer(CONFIG_START_ADDR, CONFIG_NBYTES);
         end
      end
   end

   // input driver: ready/valid patterns and slave read data
   always @(posedge ACLK) begin
      #1;
      M_AXI_ARREADY = (ar_mode == 0) ? 1'b1 : ($urandom_range(0, 2) != 0);
      case (d_mode)
         0: dout_ready = 1'b1;
         1: dout_ready = 1'($urandom_range(0, 1));
         default: begin d_tog = !d_tog; dout_ready = d_tog; end
      endcase
      if (!ARESETN || sl_addr.size() == 0) M_AXI_RVALID = 1'b0;
      else if (M_AXI_RVALID && !sl_taken) M_AXI_RVALID = 1'b1;
      else M_AXI_RVALID = (r_mode == 0) || (r_mode == 1 && $urandom_range(0, 2) != 0);
      sl_taken = 0;
      if (M_AXI_RVALID) begin
         M_AXI_RDATA = mem_word(sl_addr[0] + 32'(8 * sl_beat));
         M_AXI_RLAST = (sl_beat == int'(sl_len[0]));
         M_AXI_RRESP = (beat_count == err_beat) ? 2'b10 : 2'b00;
      end else begin
         M_AXI_RDATA = {$urandom, $urandom};
         M_AXI_RLAST = 1'b0;
         M_AXI_RRESP = 2'b00;
      end
   end

   task automatic cfg(input logic [31:0] a, input logic [31:0] n);
      @(posedge ACLK); #2;
      CONFIG_START_ADDR = a;
      CONFIG_NBYTES = n;
      CONFIG_VALID = 1'b1;
      @(posedge ACLK); #2;
      CONFIG_VALID = 1'b0;
   endtask

   task automatic wait_idle(input int budget);
      int n = 0;
      while ((exp_data.size() > 0 || exp_ar_addr.size() > 0) && n < budget) begin
         @(posedge ACLK);
         n++;
      end
      chk("timeout", 64'(n < budget), 64'd1);
      @(negedge ACLK);
      chk("idle_ready", CONFIG_READY, 1'b1);
   endtask

   initial begin
      int nb;
      logic [31:0] st;
      CONFIG_VALID = 0; CONFIG_START_ADDR = 0; CONFIG_NBYTES = 0;
      M_AXI_ARREADY = 0; M_AXI_RVALID = 0; M_AXI_RDATA = 0; M_AXI_RRESP = 0;
      M_AXI_RLAST = 0; dout_ready = 0;
      ar_mode = 0; r_mode = 0; d_mode = 0; err_beat = -1; d_tog = 0;
      repeat (3) @(posedge ACLK);
      #3;
      chk("rst_arvalid", M_AXI_ARVALID, 0);
      chk("rst_araddr", M_AXI_ARADDR, 0);
      chk("rst_rready", M_AXI_RREADY, 0);
      chk("rst_dout_valid", dout_valid, 0);
      chk("rst_error", ERROR, 0);
      chk("arsize", M_AXI_ARSIZE, 3'd3);
      chk("arburst", M_AXI_ARBURST, 2'b01);
      ARESETN = 1'b1;
      @(negedge ACLK);
      chk("rst_config_ready", CONFIG_READY, 1);

      // full 512-byte transfer, everything ready
      cfg(32'h1000, 512);
      wait_idle(1000);
      chk("t1_ars", ar_count, 4);
      chk("t1_beats", beat_count, 64);
      chk("t1_lasts", last_count, 1);

      // 25 beats: shortened final burst
      cfg(32'h1000, 200);
      wait_idle(1000);
      chk("t2_ars", ar_count, 2);
      chk("t2_beats", beat_count, 25);
      chk("t2_lasts", last_count, 1);

      // outstanding limit with read data withheld
      r_mode = 2;
      cfg(32'h2000, 1024);
      repeat (50) @(posedge ACLK);
      #3;
      chk("t3_ars_held", ar_count, 2);
      chk("t3_arvalid_low", M_AXI_ARVALID, 0);
      r_mode = 0;
      wait_idle(2000);
      chk("t3_ars", ar_count, 8);
      chk("t3_beats", beat_count, 128);

      // alternating dout_ready, random ARREADY
      d_mode = 2; ar_mode = 1;
      cfg(32'h3000, 128);
      wait_idle(1000);
      chk("t4_beats", beat_count, 16);
      chk("t4_lasts", last_count, 1);

      // SLVERR on the 5th beat
      d_mode = 0; ar_mode = 0; err_beat = 4;
      cfg(32'h4000, 128);
      wait_idle(1000);
      chk("t5_error_held", ERROR, 1);
      chk("t5_beats", beat_count, 16);
      err_beat = -1;
      cfg(32'h5000, 64);
      chk("t5_error_cleared", ERROR, 0);
      wait_idle(1000);

      // zero-length request, then reset mid-burst
      cfg(32'h6000, 4);
      repeat (5) @(posedge ACLK);
      #3;
      chk("t6_no_ar", ar_count, 0);
      chk("t6_ready", CONFIG_READY, 1);
      err_beat = 1;
      cfg(32'h7000, 256);
      repeat (6) @(posedge ACLK);
      #3;
      ARESETN = 1'b0;
      #1;
      chk("t6_rst_arvalid", M_AXI_ARVALID, 0);
      chk("t6_rst_araddr", M_AXI_ARADDR, 0);
      chk("t6_rst_rready", M_AXI_RREADY, 0);
      chk("t6_rst_dout_valid", dout_valid, 0);
      chk("t6_rst_dout_last", dout_last, 0);
      chk("t6_rst_error", ERROR, 0);
      chk("t6_rst_ready", CONFIG_READY, 1);
      @(negedge ACLK);
      @(posedge ACLK); #2;
      err_beat = -1;
      ARESETN = 1'b1;
      @(negedge ACLK);
      chk("t6_ready_after", CONFIG_READY, 1);

      // randomized transfers
      for (int t = 0; t < 8; t++) begin
         ar_mode = int'($urandom_range(0, 1));
         r_mode  = int'($urandom_range(0, 1));
         d_mode  = int'($urandom_range(0, 2));
         nb = 8 * int'($urandom_range(1, 60)) + int'($urandom_range(0, 7));
         st = (t == 0) ? 32'hFFFF_FF80 : ($urandom & 32'hFFFF_FF80);
         err_beat = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 7)) : -1;
         cfg(st, 32'(nb));
         wait_idle(5000);
         chk("rnd_beats", beat_count, nb / 8);
         chk("rnd_lasts", last_count, 1);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
